io_uart_rx: RTL

8N1 UART receiver with a receive FIFO. It converts the board's serial input (UART_TXD_IN pin) into bytes and stores them for the memory-mapped UART register file inside mfp_sys. The system reads bytes through a first-word-fall-through pop interface. Error conditions are reported as sticky flags that software clears.

---
 rtl/io_uart_rx_pkg.sv | 21 ++
 rtl/io_uart_rx_if.sv | 37 +++
 rtl/io_uart_rx_sync_fifo.sv | 68 ++++++
 rtl/io_uart_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/io_uart_rx_pkg.sv
// Shared definitions for the io_uart_rx receiver: FSM state encoding and the
// 8N1 frame constants used to place sample points within a bit.
package io_uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Tick-count values at which the receiver FSM makes a decision.
  localparam logic [3:0] OS_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_e;

endpackage

// File: rtl/io_uart_rx_if.sv
// Read and status port of the UART receiver as seen by the register file.
// The register file drives the master side; the receiver is the slave.
interface io_uart_rx_if #(
  parameter int FIFO_DEPTH = 16
) ();

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          clr_err;
  logic [7:0]    rd_data;
  logic          rx_valid;
  logic [CW-1:0] fifo_count;
  logic          overrun;
  logic          frame_err;

  modport master (
    output rd_en,
    output clr_err,
    input  rd_data,
    input  rx_valid,
    input  fifo_count,
    input  overrun,
    input  frame_err
  );

  modport slave (
    input  rd_en,
    input  clr_err,
    output rd_data,
    output rx_valid,
    output fifo_count,
    output overrun,
    output frame_err
  );

endinterface

// File: rtl/io_uart_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count. A pop and a
// push in the same cycle both take effect, even when the FIFO is full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so clearing it would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values,
  // independent of statement order or of other always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_rx.sv
// 8N1 UART receiver: input synchronizer, 16x oversample tick generator and
// frame FSM feeding an FWFT receive FIFO, with sticky overrun/frame flags.
module io_uart_rx
  import io_uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  io_uart_rx_if.slave bus
);

  localparam int                 DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int                 CW       = $clog2(FIFO_DEPTH) + 1;

  if (CLK_DIV < 2) begin : g_bad_div
    $error("io_uart_rx: CLK_DIV must be >= 2");
  end

  logic             rxd_meta;
  logic             rxd_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  rx_state_e        state;
  rx_state_e        next_state;
  logic [3:0]       os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  logic             mid_tick;
  logic             bit_tick;
  logic             sample_bit;
  logic             push;
  logic             set_frame_err;
  logic             set_overrun;

  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             overrun_q;
  logic             frame_err_q;

  // Two-flop synchronizer; resets to the idle (mark) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Divider is parked at zero in IDLE, so the first tick of a frame lands
  // exactly CLK_DIV cycles after the start edge was seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (state == IDLE || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM: next-state logic. BRK holds off reception until the line returns
  // high, so a long break is not taken as a stream of 8'h00 bytes.
  always_comb begin
    // NOTE: next_state gets a default before the case so every path assigns
    // it; a missing assignment in combinational logic would infer a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (!rxd_sync) next_state = START;
      START:   if (mid_tick)  next_state = rxd_sync ? IDLE : DATA;
      DATA:    if (bit_tick && bit_cnt == BIT_LAST) next_state = STOP;
      STOP:    if (bit_tick)  next_state = rxd_sync ? IDLE : BRK;
      BRK:     if (rxd_sync)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM: outputs and decision strobes.
  always_comb begin
    mid_tick      = tick && (os_cnt == OS_MID);
    bit_tick      = tick && (os_cnt == OS_LAST);
    sample_bit    = 1'b0;
    push          = 1'b0;
    set_frame_err = 1'b0;
    unique case (state)
      DATA: sample_bit = bit_tick;
      STOP: begin
        push          = bit_tick && rxd_sync;
        set_frame_err = bit_tick && !rxd_sync;
      end
      default: ;
    endcase
  end

  // Oversample and bit counters plus the LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (state == IDLE || (state == START && mid_tick) || bit_tick) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + 4'd1;
      end

      if (state == START) begin
        bit_cnt <= '0;
      end else if (sample_bit) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (sample_bit) begin
        shift <= {rxd_sync, shift[7:1]};
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift),
    .pop       (bus.rd_en),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A byte is lost only when the FIFO is full and the head is not leaving.
  assign set_overrun = push && fifo_full && !(bus.rd_en && !fifo_empty);

  // Sticky error flags; a new error in the clearing cycle is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (set_overrun) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        overrun_q <= 1'b0;
      end

      if (set_frame_err) begin
        frame_err_q <= 1'b1;
      end else if (bus.clr_err) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data    = fifo_head;
  assign bus.rx_valid   = !fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

endmodule
